ram_wbuf: RTL and testbench
===========================

RAM_WBUF -- requirements
Module: ram_wbuf

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 12, meaning word-address width; the array depth is 2^ADDR_W words.
REQ-002 The block SHALL have parameter DATA_W, default 32, meaning word width.
REQ-003 The block SHALL have parameter WB_DEPTH, default 4, meaning write-buffer entries; it must be a power of 2 and at least 2.
REQ-004 The block SHALL have the following ports, one per line.
  clk  in  1  single clock; all state updates on its rising edge.
  rst  in  1  synchronous, active-high reset.
  w_en  in  1  store request from core, sampled each cycle.
  w_addr_i  in  ADDR_W  store word address.
  w_data_i  in  DATA_W  store data.
  r_en  in  1  load request from core.
  r_addr_i  in  ADDR_W  load word address.
  r_data_o  out  DATA_W  load data, combinational, same cycle as r_en.
  stall_o  out  1  load not serviceable this cycle; core holds the load.
  wb_empty_o  out  1  write buffer holds no entries.

Function
REQ-005 The block SHALL contain a single-port word array: one access per cycle, either a combinational read or a drain write.
REQ-006 The block SHALL contain a circular FIFO write buffer with WB_DEPTH entries of {addr, data}, a head pointer, a tail pointer, and a count ranging 0..WB_DEPTH.
REQ-007 Enqueue: when w_en=1, {w_addr_i, w_data_i} SHALL be written at tail on the clock edge, and tail SHALL advance modulo WB_DEPTH; no store is ever dropped.
REQ-008 Drain fires (drain_fire) when count>0 AND (r_en=0 OR count==WB_DEPTH).
REQ-009 On drain_fire, the entry at head SHALL be written to array[addr] on the clock edge, and head SHALL advance modulo WB_DEPTH.
REQ-010 Simultaneous enqueue and drain: count SHALL be unchanged; enqueue while full is legal only because drain_fire is then guaranteed.
REQ-011 Count update SHALL be +1 on enqueue only, -1 on drain only, and unchanged otherwise.
REQ-012 Load hit: if r_en=1 and any valid entry matches r_addr_i, r_data_o SHALL equal the data of the newest matching entry (closest to tail), and the array SHALL NOT be read.
REQ-013 Load miss, buffer not full: r_data_o SHALL equal array[r_addr_i] and stall_o SHALL be 0.
REQ-014 Load miss, buffer full: stall_o SHALL be 1, r_data_o SHALL be 0, and the drain SHALL proceed; on the next cycle the load is serviced normally.
REQ-015 A load and a store issued in the same cycle to the same address: the load SHALL return the pre-store value, since the store is not visible until after the edge.
REQ-016 When r_en=0, r_data_o SHALL be 0 and stall_o SHALL be 0.
REQ-017 Duplicate addresses in the buffer SHALL NOT be coalesced; they drain oldest-first, so the final array value equals the last store.
REQ-018 wb_empty_o SHALL equal (count==0) and SHALL be registered-state derived, with no combinational path from inputs.
REQ-019 Pointer wrap from WB_DEPTH-1 to 0 SHALL NOT corrupt forwarding order; the newest-match search SHALL be relative to tail.
REQ-020 Implementation SHALL target 120-400 lines of RTL, with no latches and no multi-driven nets.

Reset
REQ-021 While rst=1 at the clock edge, count, head and tail SHALL become 0, and no enqueue or drain SHALL occur.
REQ-022 While rst=1, r_data_o SHALL be 0, stall_o SHALL be 0, and wb_empty_o SHALL be 1.
REQ-023 Array contents SHALL NOT be cleared by reset.
REQ-024 Buffered stores not yet drained when reset asserts SHALL be discarded, including a reset asserted mid-burst.

Verification
REQ-025 The bench SHALL cover: store 0x00A<-0xDEADBEEF with r_en=0 -> next cycle wb_empty_o=0; one cycle later it is drained, wb_empty_o=1, and a load of 0x00A returns 0xDEADBEEF via the array.
REQ-026 The bench SHALL cover: r_en held 1 (addr 0x100, miss) while 4 stores to 0x001..0x004 occur -> no drain until count=4; the 5th-cycle load miss gives stall_o=1 and r_data_o=0, and the next cycle stall_o=0.
REQ-027 The bench SHALL cover: stores 0x020<-1 then 0x020<-2 with r_en=1 on 0x020 -> r_data_o=2 (newest entry); after a full drain, array[0x020]=2.
REQ-028 The bench SHALL cover: same-cycle store 0x030<-0x55 and load 0x030 with array[0x030]=0x11 -> r_data_o=0x11 that cycle, and 0x55 the following cycle.
REQ-029 The bench SHALL cover: a full buffer plus w_en=1 every cycle for 8 cycles -> all 8 stores land in the array in order, count stays at 4, and head/tail wrap twice.
REQ-030 The bench SHALL cover: 3 buffered stores then rst=1 for one cycle -> wb_empty_o=1 and the array is unchanged at those 3 addresses.

Source files
------------

// File: rtl/ram_wbuf.sv
// ram_wbuf: single-port word RAM fronted by a circular write buffer with store-to-load forwarding
module ram_wbuf #(
  parameter int ADDR_W   = 12,
  parameter int DATA_W   = 32,
  parameter int WB_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              w_en,
  input  logic [ADDR_W-1:0] w_addr_i,
  input  logic [DATA_W-1:0] w_data_i,
  input  logic              r_en,
  input  logic [ADDR_W-1:0] r_addr_i,
  output logic [DATA_W-1:0] r_data_o,
  output logic              stall_o,
  output logic              wb_empty_o
);
  localparam int PW = $clog2(WB_DEPTH);
  localparam int CW = PW + 1;
  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [ADDR_W-1:0] wa_q [WB_DEPTH];
  logic [DATA_W-1:0] wd_q [WB_DEPTH];
  logic [PW-1:0] head_q, head_d, tail_q, tail_d, idx;
  logic [CW-1:0] cnt_q, cnt_d;
  logic full, drain, hit;
  logic [DATA_W-1:0] hit_data;
  assign full       = cnt_q == CW'(WB_DEPTH);
  assign drain      = !rst && cnt_q != '0 && (!r_en || full);
  assign wb_empty_o = cnt_q == '0;
  // walk valid entries oldest to newest from head so the last match is the newest store
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    idx      = '0;
    for (int i = 0; i < WB_DEPTH; i++) begin
      idx = head_q + PW'(i);
      if (CW'(i) < cnt_q && wa_q[idx] == r_addr_i) begin
        hit      = 1'b1;
        hit_data = wd_q[idx];
      end
    end
  end
  // load result: forwarded data, array read, or stall while a full buffer drains
  always_comb begin
    r_data_o = (rst || !r_en) ? '0 : hit ? hit_data : full ? '0 : mem_q[r_addr_i];
    stall_o  = !rst && r_en && !hit && full;
  end
  // pointer and occupancy next state
  always_comb begin
    head_d = drain ? head_q + PW'(1) : head_q;
    tail_d = w_en ? tail_q + PW'(1) : tail_q;
    cnt_d  = cnt_q + CW'(w_en) - CW'(drain);
  end
  // buffer control state; reset discards undrained stores
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end
  // buffer entry capture at tail
  always_ff @(posedge clk) begin
    if (!rst && w_en) begin
      wa_q[tail_q] <= w_addr_i;
      wd_q[tail_q] <= w_data_i;
    end
  end
  // drain head entry into the array; array contents survive reset
  always_ff @(posedge clk) begin
    if (drain) mem_q[wa_q[head_q]] <= wd_q[head_q];
  end
endmodule

// File: tb/tb_ram_wbuf.sv
// tb_ram_wbuf: directed self-checking bench for ram_wbuf
module tb_ram_wbuf;
  logic        clk = 1'b0;
  logic        rst, w_en, r_en;
  logic [11:0] w_addr_i, r_addr_i;
  logic [31:0] w_data_i, r_data_o;
  logic        stall_o, wb_empty_o;
  int checks = 0;
  int failures = 0;

  ram_wbuf dut (
    .clk(clk), .rst(rst), .w_en(w_en), .w_addr_i(w_addr_i), .w_data_i(w_data_i),
    .r_en(r_en), .r_addr_i(r_addr_i), .r_data_o(r_data_o), .stall_o(stall_o),
    .wb_empty_o(wb_empty_o)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic st(input logic [11:0] a, input logic [31:0] d);
    w_en = 1'b1;
    w_addr_i = a;
    w_data_i = d;
  endtask

  task automatic ld(input string tag, input logic [11:0] a, input logic [31:0] exp);
    r_en = 1'b1;
    r_addr_i = a;
    #1;
    chk(tag, r_data_o, exp);
    chk({tag, "_stall"}, {31'b0, stall_o}, 0);
    r_en = 1'b0;
    cyc();
  endtask

  initial begin
    rst = 1'b1; w_en = 1'b0; r_en = 1'b0;
    w_addr_i = '0; w_data_i = '0; r_addr_i = '0;
    cyc(); cyc();
    r_en = 1'b1; r_addr_i = 12'h005;
    #1;
    chk("rst_empty", {31'b0, wb_empty_o}, 1);
    chk("rst_rdata", r_data_o, 0);
    chk("rst_stall", {31'b0, stall_o}, 0);
    rst = 1'b0; r_en = 1'b0;
    cyc();

    st(12'h00A, 32'hDEADBEEF);
    cyc();
    w_en = 1'b0;
    #1;
    chk("t1_not_empty", {31'b0, wb_empty_o}, 0);
    chk("t1_ren0_rdata", r_data_o, 0);
    cyc();
    chk("t1_drained", {31'b0, wb_empty_o}, 1);
    ld("t1_load", 12'h00A, 32'hDEADBEEF);

    st(12'h100, 32'h1234);
    cyc();
    w_en = 1'b0;
    cyc();
    r_en = 1'b1; r_addr_i = 12'h100;
    for (int k = 1; k <= 4; k++) begin
      st(12'(k), 32'(k * 16));
      #1;
      chk("t2_fill_stall", {31'b0, stall_o}, 0);
      chk("t2_fill_rdata", r_data_o, 32'h1234);
      cyc();
    end
    w_en = 1'b0;
    #1;
    chk("t2_full_stall", {31'b0, stall_o}, 1);
    chk("t2_full_rdata", r_data_o, 0);
    cyc();
    chk("t2_after_stall", {31'b0, stall_o}, 0);
    chk("t2_after_rdata", r_data_o, 32'h1234);
    r_en = 1'b0;
    cyc(); cyc(); cyc();
    chk("t2_empty", {31'b0, wb_empty_o}, 1);
    for (int k = 1; k <= 4; k++) ld("t2_array", 12'(k), 32'(k * 16));

    r_en = 1'b1; r_addr_i = 12'h020;
    st(12'h020, 32'd1);
    cyc();
    st(12'h020, 32'd2);
    #1;
    chk("t3_fwd_one", r_data_o, 32'd1);
    cyc();
    w_en = 1'b0;
    #1;
    chk("t3_fwd_newest", r_data_o, 32'd2);
    r_en = 1'b0;
    cyc(); cyc();
    chk("t3_empty", {31'b0, wb_empty_o}, 1);
    ld("t3_array", 12'h020, 32'd2);

    st(12'h030, 32'h11);
    cyc();
    w_en = 1'b0;
    cyc();
    st(12'h030, 32'h55);
    r_en = 1'b1; r_addr_i = 12'h030;
    #1;
    chk("t4_same_cycle", r_data_o, 32'h11);
    cyc();
    w_en = 1'b0;
    #1;
    chk("t4_next_cycle", r_data_o, 32'h55);
    r_en = 1'b0;
    cyc();
    chk("t4_empty", {31'b0, wb_empty_o}, 1);
    ld("t4_array", 12'h030, 32'h55);

    r_en = 1'b1; r_addr_i = 12'h0FF;
    for (int k = 0; k < 4; k++) begin
      st(12'h040 + 12'(k), 32'h300 + 32'(k));
      cyc();
    end
    for (int k = 0; k < 8; k++) begin
      st(12'h050 + 12'(k % 4), 32'h200 + 32'(k));
      #1;
      chk("t5_full_stall", {31'b0, stall_o}, 1);
      chk("t5_full_rdata", r_data_o, 0);
      cyc();
    end
    w_en = 1'b0;
    #1;
    chk("t5_still_full", {31'b0, stall_o}, 1);
    r_en = 1'b0;
    cyc(); cyc(); cyc(); cyc();
    chk("t5_empty", {31'b0, wb_empty_o}, 1);
    for (int k = 0; k < 4; k++) ld("t5_fill_arr", 12'h040 + 12'(k), 32'h300 + 32'(k));
    for (int k = 0; k < 4; k++) ld("t5_burst_arr", 12'h050 + 12'(k), 32'h204 + 32'(k));

    for (int k = 0; k < 3; k++) begin
      st(12'h060 + 12'(k), 32'hA0 + 32'(k));
      cyc();
    end
    w_en = 1'b0;
    cyc(); cyc(); cyc();
    r_en = 1'b1; r_addr_i = 12'h0FF;
    for (int k = 0; k < 3; k++) begin
      st(12'h060 + 12'(k), 32'hB0 + 32'(k));
      cyc();
    end
    w_en = 1'b0;
    chk("t6_pre_rst", {31'b0, wb_empty_o}, 0);
    rst = 1'b1;
    #1;
    chk("t6_rst_rdata", r_data_o, 0);
    chk("t6_rst_stall", {31'b0, stall_o}, 0);
    cyc();
    rst = 1'b0; r_en = 1'b0;
    #1;
    chk("t6_empty", {31'b0, wb_empty_o}, 1);
    cyc(); cyc();
    chk("t6_still_empty", {31'b0, wb_empty_o}, 1);
    for (int k = 0; k < 3; k++) ld("t6_array", 12'h060 + 12'(k), 32'hA0 + 32'(k));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
